// File: rtl/neopix_frame_feeder_pkg.sv
// +----------------------------------------------------------------------+
// | neopix_pkg: shared types and timing constants for the frame feeder.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package neopix_pkg;

  localparam int CLK_HZ   = 50_000_000;
  localparam int LATCH_US = 52;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } feeder_state_t;

  function automatic logic [23:0] scale_grb(input logic [23:0] word, input logic [2:0] shift);
    grb_t px;
    px   = word;
    px.g = px.g >> shift;
    px.r = px.r >> shift;
    px.b = px.b >> shift;
    return px;
  endfunction

endpackage

`default_nettype wire

// File: rtl/neopix_frame_feeder_if.sv
// +----------------------------------------------------------------------+
// | neopix_frame_feeder_if: back-buffer write port and pixel stream.      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

interface neopix_frame_feeder_if #(
  parameter int NUM_PIXELS = 64
);
  localparam int ADDR_W = $clog2(NUM_PIXELS);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic              swap_req;
  logic [23:0]       pix_data;
  logic              pix_valid;
  logic              pix_ready;

  modport master (
    output wr_en, wr_addr, wr_data, swap_req, pix_ready,
    input  pix_data, pix_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, swap_req, pix_ready,
    output pix_data, pix_valid
  );
endinterface

`default_nettype wire

// File: rtl/neopix_frame_feeder_pixel_bank.sv
// +----------------------------------------------------------------------+
// | neopix_pixel_bank: NUM_PIXELS x 24 store, one write port, async read. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module neopix_pixel_bank #(
  parameter int NUM_PIXELS = 64,
  parameter int ADDR_W     = $clog2(NUM_PIXELS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [23:0]       rd_data
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(NUM_PIXELS);

  logic [23:0] mem [NUM_PIXELS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_PIXELS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && ({1'b0, wr_addr} < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = ({1'b0, rd_addr} < DEPTH) ? mem[rd_addr] : '0;

endmodule

`default_nettype wire

// File: rtl/neopix_frame_feeder.sv
// +----------------------------------------------------------------------+
// | neopix_frame_feeder: double-buffered pixel streamer with latch gap.   |
// | Optional macro NEOPIX_BRIGHTNESS_SCALE_EN adds per-frame dimming.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module neopix_frame_feeder
  import neopix_pkg::*;
#(
  parameter int NUM_PIXELS   = 64,
  parameter int LATCH_CYCLES = (CLK_HZ / 1_000_000) * LATCH_US
) (
  input  logic                 clock,
  input  logic                 reset,
  neopix_frame_feeder_if.slave bus,
`ifdef NEOPIX_BRIGHTNESS_SCALE_EN
  input  logic [2:0]           brightness,
`endif
  output logic                 frame_busy,
  output logic                 frame_done,
  output logic [15:0]          frames_sent
);

  localparam int ADDR_W = $clog2(NUM_PIXELS);
  localparam int CNT_W  = $clog2(LATCH_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);

  feeder_state_t     state, state_n;
  logic              front_sel, front_sel_n;
  logic              swap_pending, pending_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              valid_n, done_n;
  logic [23:0]       data_n;
  logic [15:0]       sent_n;

  logic              xfer, advance, start, rd_front;
  logic [ADDR_W-1:0] rd_addr;
  logic [23:0]       rd0, rd1, rd_word, out_word;

  // A new frame begins either from IDLE or straight out of LATCH when a swap is owed.
  assign xfer     = bus.pix_valid & bus.pix_ready;
  assign advance  = (state == SEND) && xfer && (idx != LAST_IDX);
  assign start    = ((state == IDLE) && bus.swap_req) ||
                    ((state == LATCH) && (cnt == '0) && (swap_pending || bus.swap_req));
  assign rd_addr  = advance ? ADDR_W'(idx + 1'b1) : '0;
  assign rd_front = start ? ~front_sel : front_sel;
  assign rd_word  = rd_front ? rd1 : rd0;

`ifdef NEOPIX_BRIGHTNESS_SCALE_EN
  logic [2:0] bright, bright_n;
  assign bright_n = start ? brightness : bright;
  assign out_word = scale_grb(rd_word, bright_n);
  always_ff @(posedge clock) begin
    if (reset) bright <= '0;
    else       bright <= bright_n;
  end
`else
  assign out_word = rd_word;
`endif

  neopix_pixel_bank #(.NUM_PIXELS(NUM_PIXELS), .ADDR_W(ADDR_W)) u_bank0 (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (bus.wr_en & front_sel),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd0)
  );

  neopix_pixel_bank #(.NUM_PIXELS(NUM_PIXELS), .ADDR_W(ADDR_W)) u_bank1 (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (bus.wr_en & ~front_sel),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd1)
  );

  always_comb begin
    state_n     = state;
    front_sel_n = front_sel;
    pending_n   = swap_pending | bus.swap_req;
    idx_n       = idx;
    cnt_n       = cnt;
    valid_n     = bus.pix_valid;
    data_n      = bus.pix_data;
    done_n      = 1'b0;
    sent_n      = frames_sent;
    case (state)
      IDLE: begin
        pending_n = 1'b0;
        if (bus.swap_req) state_n = SEND;
      end
      SEND: begin
        if (advance) begin
          idx_n  = ADDR_W'(idx + 1'b1);
          data_n = out_word;
        end else if (xfer) begin
          valid_n = 1'b0;
          cnt_n   = CNT_W'(LATCH_CYCLES - 1);
          state_n = LATCH;
        end
      end
      LATCH: begin
        if (cnt == '0) begin
          done_n  = 1'b1;
          sent_n  = frames_sent + 16'd1;
          state_n = start ? SEND : IDLE;
          if (start) pending_n = 1'b0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (start) begin
      front_sel_n = ~front_sel;
      idx_n       = '0;
      valid_n     = 1'b1;
      data_n      = out_word;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      front_sel     <= 1'b0;
      swap_pending  <= 1'b0;
      idx           <= '0;
      cnt           <= '0;
      bus.pix_valid <= 1'b0;
      bus.pix_data  <= '0;
      frame_done    <= 1'b0;
      frames_sent   <= '0;
    end else begin
      state         <= state_n;
      front_sel     <= front_sel_n;
      swap_pending  <= pending_n;
      idx           <= idx_n;
      cnt           <= cnt_n;
      bus.pix_valid <= valid_n;
      bus.pix_data  <= data_n;
      frame_done    <= done_n;
      frames_sent   <= sent_n;
    end
  end

  assign frame_busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_neopix_frame_feeder.sv
// +----------------------------------------------------------------------+
// | tb_neopix_frame_feeder: directed self-checking bench for the feeder.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_neopix_frame_feeder;

  logic        clock;
  logic        reset;
  logic        a_frame_busy, a_frame_done, b_frame_busy, b_frame_done;
  logic [15:0] a_frames_sent, b_frames_sent;
  logic [2:0]  brightness;

  int tests;
  int fails;
  int exp_frames;
  bit msel;
  logic [23:0] mdl [2][64];

  neopix_frame_feeder_if #(.NUM_PIXELS(64)) a ();
  neopix_frame_feeder_if #(.NUM_PIXELS(5))  b ();

  neopix_frame_feeder #(.NUM_PIXELS(64), .LATCH_CYCLES(2600)) dut_a (
    .clock       (clock),
    .reset       (reset),
    .bus         (a),
`ifdef NEOPIX_BRIGHTNESS_SCALE_EN
    .brightness  (brightness),
`endif
    .frame_busy  (a_frame_busy),
    .frame_done  (a_frame_done),
    .frames_sent (a_frames_sent)
  );

  neopix_frame_feeder #(.NUM_PIXELS(5), .LATCH_CYCLES(4)) dut_b (
    .clock       (clock),
    .reset       (reset),
    .bus         (b),
`ifdef NEOPIX_BRIGHTNESS_SCALE_EN
    .brightness  (brightness),
`endif
    .frame_busy  (b_frame_busy),
    .frame_done  (b_frame_done),
    .frames_sent (b_frames_sent)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 64; i++) begin
      a.wr_en   = 1'b1;
      a.wr_addr = 6'(i);
      a.wr_data = {base + 8'(i), 8'h00, 8'hFF};
      mdl[msel ? 0 : 1][i] = a.wr_data;
      tick;
    end
    a.wr_en = 1'b0;
  endtask

  task automatic swap;
    a.swap_req = 1'b1;
    tick;
    a.swap_req = 1'b0;
    msel = !msel;
  endtask

  // Streams the current front frame from the present sample point, then its latch gap.
  task automatic stream_frame(input bit stall, input bit mid_ops, input int abort_at);
    int got, cyc, lat, viol, lviol;
    bit holding;
    logic [23:0] hold;
    got = 0; cyc = 0; lat = 0; viol = 0; lviol = 0; holding = 0; hold = '0;
    while (got < 64 && cyc < 3000) begin
      if (got == abort_at) return;
      a.swap_req  = 1'b0;
      a.wr_en     = 1'b0;
      a.pix_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (holding && (!a.pix_valid || a.pix_data !== hold)) viol++;
      holding = 0;
      if (a.pix_valid && a.pix_ready) begin
        check("pixel", a.pix_data, mdl[msel][got]);
        if (mid_ops && got == 10) begin
          a.swap_req = 1'b1;
          a.wr_en    = 1'b1;
          a.wr_addr  = 6'd5;
          a.wr_data  = 24'hABCDEF;
          mdl[msel ? 0 : 1][5] = 24'hABCDEF;
        end
        got++;
      end else if (a.pix_valid) begin
        holding = 1;
        hold    = a.pix_data;
      end
      tick;
      cyc++;
    end
    a.swap_req  = 1'b0;
    a.wr_en     = 1'b0;
    a.pix_ready = 1'b1;
    check("pixel_count", got, 64);
    check("stall_hold", viol, 0);
    while (!a_frame_done && lat < 4000) begin
      a.swap_req = (mid_ops && lat == 100);
      if (a.pix_valid) lviol++;
      lat++;
      tick;
    end
    a.swap_req = 1'b0;
    check("latch_len", lat, 2600);
    check("valid_in_latch", lviol, 0);
    check("frame_done", a_frame_done, 1);
    exp_frames++;
    check("frames_sent", a_frames_sent, exp_frames);
    if (mid_ops) begin
      check("followon_valid", a.pix_valid, 1);
      msel = !msel;
    end else begin
      tick;
      check("done_pulse_len", a_frame_done, 0);
      check("idle_busy", a_frame_busy, 0);
    end
  endtask

  initial begin
    int dones, lat;
    tests = 0; fails = 0; exp_frames = 0; msel = 0;
    brightness = 3'd0;
    for (int k = 0; k < 2; k++) for (int i = 0; i < 64; i++) mdl[k][i] = '0;
    reset = 1'b1;
    a.wr_en = 0; a.wr_addr = '0; a.wr_data = '0; a.swap_req = 0; a.pix_ready = 0;
    b.wr_en = 0; b.wr_addr = '0; b.wr_data = '0; b.swap_req = 0; b.pix_ready = 0;
    tick; tick; tick;
    reset = 1'b0;
    check("rst_valid", a.pix_valid, 0);
    check("rst_data", a.pix_data, 0);
    check("rst_busy", a_frame_busy, 0);
    check("rst_done", a_frame_done, 0);
    check("rst_sent", a_frames_sent, 0);

    // Plain frame, constant ready.
    fill(8'h10);
    swap;
    stream_frame(0, 0, -1);

    // Random back-pressure.
    fill(8'h40);
    swap;
    stream_frame(1, 0, -1);

    // Swap requested mid-frame and again in the gap; one follow-on frame only.
    fill(8'h80);
    swap;
    stream_frame(0, 1, -1);
    stream_frame(0, 0, -1);

    // Reset in the middle of a frame.
    fill(8'hC0);
    swap;
    stream_frame(0, 0, 30);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("abort_valid", a.pix_valid, 0);
    check("abort_busy", a_frame_busy, 0);
    check("abort_sent", a_frames_sent, 0);
    check("abort_data", a.pix_data, 0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (a_frame_done) dones++;
      tick;
    end
    check("abort_no_done", dones, 0);
    swap;
    check("post_reset_valid", a.pix_valid, 1);
    check("post_reset_pix0", a.pix_data, 0);
    a.pix_ready = 1'b0;

    // Small instance: out-of-range writes must leave the bank untouched.
    for (int i = 0; i < 8; i++) begin
      b.wr_en   = 1'b1;
      b.wr_addr = 3'(i);
      b.wr_data = (i < 5) ? (24'h0A0B00 + 24'(i)) : 24'hFFFFFF;
      tick;
    end
    b.wr_en    = 1'b0;
    b.swap_req = 1'b1;
    tick;
    b.swap_req  = 1'b0;
    b.pix_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("b_pixel", {7'd0, b.pix_valid, b.pix_data}, {8'h01, 24'h0A0B00 + 24'(i)});
      tick;
    end
    lat = 0;
    while (!b_frame_done && lat < 20) begin
      lat++;
      tick;
    end
    check("b_latch_len", lat, 4);
    check("b_frames_sent", b_frames_sent, 1);
    tick;
    check("b_idle", {b_frame_busy, b.pix_valid}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
